// File: rtl/cop_wb_queue_if.sv
// Handshake bundle between co-processor, write-back queue, register file and hazard unit.
// slave = queue side; master = the surrounding pipeline driving it.
interface cop_wb_queue_if #(
    parameter int AW = 2
);
    logic        cop_wr;
    logic [31:0] cop_insn;
    logic [31:0] cop_rd;
    logic        cop_rdywr;
    logic        flush;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ack;
    logic [4:0]  chk_addr;
    logic        chk_pending;
    logic [AW:0] occ;

    modport slave (
        input  cop_wr, cop_insn, cop_rd, flush, rf_ack, chk_addr,
        output cop_rdywr, rf_wen, rf_waddr, rf_wdata, chk_pending, occ
    );

    modport master (
        output cop_wr, cop_insn, cop_rd, flush, rf_ack, chk_addr,
        input  cop_rdywr, rf_wen, rf_waddr, rf_wdata, chk_pending, occ
    );
endinterface

// File: rtl/cop_wb_queue.sv
// In-order write-back FIFO from co-processor results to the register-file port; push visible on rf_wen one edge later.
// Back-pressure: cop_rdywr drops while full; the head holds stable until rf_ack.
module cop_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic           cop_clk,
    input  logic           cop_rst,
    cop_wb_queue_if.slave  q
);
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] dat;
    } entry_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [4:0]    wr_idx;
    logic          pend;
    logic [AW-1:0] slot;
    logic          unused_insn;

    assign wr_idx      = q.cop_insn[11:7];
    assign unused_insn = ^{q.cop_insn[31:12], q.cop_insn[6:0]};

    assign full  = (cnt == DEPTH_C);
    assign empty = (cnt == '0);

    // x0 writes are acknowledged (rdywr stays high) but never occupy a slot
    assign push = q.cop_wr & ~full & (wr_idx != 5'd0);
    assign pop  = ~empty & q.rf_ack;

    always_ff @(posedge cop_clk or negedge cop_rst) begin
        if (!cop_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage needs no reset: every read is qualified by cnt
    always_ff @(posedge cop_clk) begin
        if (push) mem[wr_ptr] <= '{idx: wr_idx, dat: q.cop_rd};
    end

    assign head       = mem[rd_ptr];
    assign q.rf_wen   = ~empty;
    assign q.rf_waddr = empty ? 5'd0  : head.idx;
    assign q.rf_wdata = empty ? 32'd0 : head.dat;
    assign q.cop_rdywr = ~full;
    assign q.occ      = cnt;

    always_comb begin
        pend = 1'b0;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + AW'(i);
            if (((AW+1)'(i) < cnt) && (mem[slot].idx == q.chk_addr)) pend = 1'b1;
        end
    end

    assign q.chk_pending = pend & (q.chk_addr != 5'd0);
endmodule

// File: tb/tb_cop_wb_queue.sv
// Bench for cop_wb_queue: directed plan with literal expectations plus randomized traffic against a queue model.
module tb_cop_wb_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic cop_clk = 1'b0;
    logic cop_rst = 1'b0;
    int   errs    = 0;
    int   checks  = 0;

    always #5 cop_clk = ~cop_clk;

    cop_wb_queue_if #(.AW(AW)) wbq ();

    cop_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .cop_clk (cop_clk),
        .cop_rst (cop_rst),
        .q       (wbq.slave)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] dat;
    } ent_t;

    ent_t mq[$];

    // Reference: a plain queue updated with the acceptance rules
    always @(posedge cop_clk or negedge cop_rst) begin
        if (!cop_rst) begin
            mq.delete();
        end else if (wbq.flush) begin
            mq.delete();
        end else begin
            bit   do_pop;
            bit   do_push;
            ent_t e;
            do_pop  = (mq.size() > 0) && wbq.rf_ack;
            do_push = wbq.cop_wr && (mq.size() < DEPTH) && (wbq.cop_insn[11:7] != 5'd0);
            e.idx   = wbq.cop_insn[11:7];
            e.dat   = wbq.cop_rd;
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge cop_clk) begin
        bit pend_m;
        pend_m = 1'b0;
        foreach (mq[i]) if (mq[i].idx == wbq.chk_addr) pend_m = 1'b1;
        if (wbq.chk_addr == 5'd0) pend_m = 1'b0;
        chk("m_rdywr", 32'(wbq.cop_rdywr), 32'(mq.size() < DEPTH));
        chk("m_wen",   32'(wbq.rf_wen),    32'(mq.size() > 0));
        chk("m_occ",   32'(wbq.occ),       32'(mq.size()));
        chk("m_waddr", 32'(wbq.rf_waddr),  (mq.size() > 0) ? 32'(mq[0].idx) : 32'd0);
        chk("m_wdata", wbq.rf_wdata,       (mq.size() > 0) ? mq[0].dat : 32'd0);
        chk("m_pend",  32'(wbq.chk_pending), 32'(pend_m));
    end

    task automatic cyc(input bit wr, input logic [4:0] idx, input logic [31:0] dat,
                       input bit ack, input bit fl);
        logic [31:0] ins;
        ins        = $urandom;
        ins[11:7]  = idx;
        wbq.cop_wr   = wr;
        wbq.cop_insn = ins;
        wbq.cop_rd   = dat;
        wbq.rf_ack   = ack;
        wbq.flush    = fl;
        @(posedge cop_clk);
        #1;
        wbq.cop_wr = 1'b0;
        wbq.rf_ack = 1'b0;
        wbq.flush  = 1'b0;
    endtask

    initial begin
        logic [4:0] exp_h;
        logic [4:0] order [4];
        wbq.cop_wr   = 1'b0;
        wbq.cop_insn = '0;
        wbq.cop_rd   = '0;
        wbq.rf_ack   = 1'b0;
        wbq.flush    = 1'b0;
        wbq.chk_addr = '0;
        repeat (3) @(posedge cop_clk);
        #1;
        chk("rst_rdywr", 32'(wbq.cop_rdywr), 32'd1);
        chk("rst_wen",   32'(wbq.rf_wen),    32'd0);
        chk("rst_occ",   32'(wbq.occ),       32'd0);
        chk("rst_wdata", wbq.rf_wdata,       32'd0);
        cop_rst = 1'b1;
        @(posedge cop_clk);
        #1;

        // basic latency
        cyc(1, 5'd5, 32'hDEADBEEF, 0, 0);
        chk("t1_wen",   32'(wbq.rf_wen),   32'd1);
        chk("t1_waddr", 32'(wbq.rf_waddr), 32'd5);
        chk("t1_wdata", wbq.rf_wdata,      32'hDEADBEEF);
        chk("t1_occ",   32'(wbq.occ),      32'd1);
        cyc(0, 5'd0, 32'd0, 1, 0);
        chk("t1_wen0",  32'(wbq.rf_wen),   32'd0);
        chk("t1_occ0",  32'(wbq.occ),      32'd0);

        // fill and back-pressure; the 5th result is held through a full-cycle pop
        for (int i = 1; i <= 4; i++) cyc(1, 5'(i), 32'(i) * 32'h11, 0, 0);
        chk("t2_occ4",  32'(wbq.occ),       32'd4);
        chk("t2_rdy0",  32'(wbq.cop_rdywr), 32'd0);
        cyc(1, 5'd6, 32'h66, 0, 0);
        chk("t2_nostore", 32'(wbq.occ),     32'd4);
        chk("t2_head1", 32'(wbq.rf_waddr),  32'd1);
        cyc(1, 5'd6, 32'h66, 1, 0);
        chk("t2_occ3",  32'(wbq.occ),       32'd3);
        chk("t2_rdy1",  32'(wbq.cop_rdywr), 32'd1);
        cyc(1, 5'd6, 32'h66, 0, 0);
        chk("t2_occ4b", 32'(wbq.occ),       32'd4);
        order = '{5'd2, 5'd3, 5'd4, 5'd6};
        for (int k = 0; k < 4; k++) begin
            chk("t2_order", 32'(wbq.rf_waddr), 32'(order[k]));
            cyc(0, 5'd0, 32'd0, 1, 0);
        end
        chk("t2_empty", 32'(wbq.occ), 32'd0);

        // simultaneous push and pop across pointer wrap
        cyc(1, 5'd20, 32'd20 * 32'h100, 0, 0);
        cyc(1, 5'd21, 32'd21 * 32'h100, 0, 0);
        for (int k = 0; k < 10; k++) begin
            exp_h = (k == 0) ? 5'd20 : (k == 1) ? 5'd21 : 5'(5 + k);
            chk("t3_head", 32'(wbq.rf_waddr), 32'(exp_h));
            chk("t3_data", wbq.rf_wdata,      32'(exp_h) * 32'h100);
            cyc(1, 5'(7 + k), 32'(7 + k) * 32'h100, 1, 0);
            chk("t3_occ",  32'(wbq.occ),      32'd2);
        end
        chk("t3_tail0", 32'(wbq.rf_waddr), 32'd15);
        cyc(0, 5'd0, 32'd0, 1, 0);
        chk("t3_tail1", 32'(wbq.rf_waddr), 32'd16);
        cyc(0, 5'd0, 32'd0, 1, 0);
        chk("t3_empty", 32'(wbq.occ), 32'd0);

        // x0 destination is accepted but dropped
        cyc(1, 5'd0, 32'h12345678, 0, 0);
        chk("t4_occ",  32'(wbq.occ),       32'd0);
        chk("t4_wen",  32'(wbq.rf_wen),    32'd0);
        chk("t4_rdy",  32'(wbq.cop_rdywr), 32'd1);

        // hazard check
        cyc(1, 5'd9,  32'h99, 0, 0);
        cyc(1, 5'd12, 32'hCC, 0, 0);
        wbq.chk_addr = 5'd12; #1;
        chk("t5_p12", 32'(wbq.chk_pending), 32'd1);
        wbq.chk_addr = 5'd13; #1;
        chk("t5_p13", 32'(wbq.chk_pending), 32'd0);
        wbq.chk_addr = 5'd0;  #1;
        chk("t5_p0",  32'(wbq.chk_pending), 32'd0);
        wbq.chk_addr = 5'd12;
        cyc(0, 5'd0, 32'd0, 1, 0);
        chk("t5_p12b", 32'(wbq.chk_pending), 32'd1);
        cyc(0, 5'd0, 32'd0, 1, 0);
        chk("t5_p12c", 32'(wbq.chk_pending), 32'd0);

        // flush beats concurrent push and pop
        for (int i = 1; i <= 3; i++) cyc(1, 5'(i), 32'(i), 0, 0);
        chk("t6_occ3", 32'(wbq.occ), 32'd3);
        cyc(1, 5'd4, 32'h4, 1, 1);
        chk("t6_fl_occ", 32'(wbq.occ),    32'd0);
        chk("t6_fl_wen", 32'(wbq.rf_wen), 32'd0);

        // asynchronous reset mid-cycle with two entries queued
        cyc(1, 5'd5, 32'h5, 0, 0);
        cyc(1, 5'd6, 32'h6, 0, 0);
        chk("t6_occ2", 32'(wbq.occ), 32'd2);
        #2;
        cop_rst = 1'b0;
        #1;
        chk("t6_arst_wen", 32'(wbq.rf_wen),    32'd0);
        chk("t6_arst_occ", 32'(wbq.occ),       32'd0);
        chk("t6_arst_rdy", 32'(wbq.cop_rdywr), 32'd1);
        @(posedge cop_clk);
        #1;
        cop_rst = 1'b1;
        cyc(0, 5'd0, 32'd0, 0, 0);
        chk("t6_rel_occ", 32'(wbq.occ),    32'd0);
        chk("t6_rel_wen", 32'(wbq.rf_wen), 32'd0);

        // randomized traffic, checked every cycle by the model compare
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            ins       = $urandom;
            ins[11:7] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wbq.cop_wr   = ($urandom_range(0, 2) != 0);
            wbq.cop_insn = ins;
            wbq.cop_rd   = $urandom;
            wbq.rf_ack   = ($urandom_range(0, 1) == 1);
            wbq.flush    = ($urandom_range(0, 39) == 0);
            wbq.chk_addr = ($urandom_range(0, 1) == 1 && mq.size() > 0)
                           ? mq[$urandom_range(0, mq.size() - 1)].idx : 5'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                cop_rst = 1'b0;
                #2;
                cop_rst = 1'b1;
            end
            @(posedge cop_clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
